// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard unit
package hazard_pkg;

    localparam int MULDIV_LAT_DEFAULT = 32;
    localparam int CNT_W              = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_timer.sv
// rtl/muldiv_timer.sv - mul/div occupancy FSM and latency down-counter
// Holds a mul/div op in EX for MULDIV_LAT cycles, then one DONE cycle.
module muldiv_timer
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic muldiv_i,
    input  logic dmem_stall_i,
    output logic start_o,
    output logic stall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_o = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                // A new op only launches once memory is ready and reset is released.
                if (muldiv_i && !dmem_stall_i && !rst_i) begin
                    start_o = 1'b1;
                    stall_o = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!dmem_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == BUSY) || (state_q == DONE);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush priority logic
// Mul/div occupancy tracking is included only when MULDIV_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] IFID_rs1_i,
    input  logic [4:0] IFID_rs2_i,
    input  logic [4:0] IDEX_rd_i,
    input  logic       IDEX_memrd_i,
    input  logic       IDEX_muldiv_i,
    input  logic       branch_taken_i,
    input  logic       dmem_stall_i,
    output logic       pc_stall_o,
    output logic       ifid_stall_o,
    output logic       idex_stall_o,
    output logic       exmem_stall_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       muldiv_start_o,
    output logic       muldiv_busy_o
);

    logic md_stall;
    logic load_use;

`ifdef MULDIV_EN
    muldiv_timer #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_muldiv_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .muldiv_i    (IDEX_muldiv_i),
        .dmem_stall_i(dmem_stall_i),
        .start_o     (muldiv_start_o),
        .stall_o     (md_stall),
        .busy_o      (muldiv_busy_o)
    );
`else
    logic unused_md;
    assign unused_md      = ^{clk_i, rst_i, IDEX_muldiv_i, 7'(MULDIV_LAT)};
    assign md_stall       = 1'b0;
    assign muldiv_start_o = 1'b0;
    assign muldiv_busy_o  = 1'b0;
`endif

    assign load_use = IDEX_memrd_i && (IDEX_rd_i != 5'd0) &&
                      ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

    // Priority: memory stall, then mul/div occupancy, then branch flush, then load-use.
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        idex_stall_o  = 1'b0;
        exmem_stall_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        if (dmem_stall_i) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
        end else if (md_stall) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam int LAT = 4;
`ifdef MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk_i;
    logic       rst_i;
    logic [4:0] IFID_rs1_i, IFID_rs2_i, IDEX_rd_i;
    logic       IDEX_memrd_i, IDEX_muldiv_i, branch_taken_i, dmem_stall_i;
    logic       pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o;
    logic       ifid_flush_o, idex_flush_o, muldiv_start_o, muldiv_busy_o;
    logic [7:0] outs;

    hazard_unit #(.MULDIV_LAT(LAT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .IFID_rs1_i    (IFID_rs1_i),
        .IFID_rs2_i    (IFID_rs2_i),
        .IDEX_rd_i     (IDEX_rd_i),
        .IDEX_memrd_i  (IDEX_memrd_i),
        .IDEX_muldiv_i (IDEX_muldiv_i),
        .branch_taken_i(branch_taken_i),
        .dmem_stall_i  (dmem_stall_i),
        .pc_stall_o    (pc_stall_o),
        .ifid_stall_o  (ifid_stall_o),
        .idex_stall_o  (idex_stall_o),
        .exmem_stall_o (exmem_stall_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_flush_o  (idex_flush_o),
        .muldiv_start_o(muldiv_start_o),
        .muldiv_busy_o (muldiv_busy_o)
    );

    assign outs = {pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
                   ifid_flush_o, idex_flush_o, muldiv_start_o, muldiv_busy_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    // Model state: cycles elapsed since the current mul/div op started (0 = none).
    int age      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        bit lu, busy, done, st, mds;
        lu   = IDEX_memrd_i && (IDEX_rd_i != 0) &&
               (IDEX_rd_i == IFID_rs1_i || IDEX_rd_i == IFID_rs2_i);
        busy = MD_EN && (age > 0);
        done = busy && (age >= LAT);
        st   = MD_EN && !busy && IDEX_muldiv_i && !dmem_stall_i && !rst_i;
        mds  = st || (busy && !done);
        o = 8'h00;
        if (dmem_stall_i)        o[7:4] = 4'hF;
        else if (mds)            o[7:5] = 3'b111;
        else if (branch_taken_i) o[3:2] = 2'b11;
        else if (lu)             begin o[7] = 1'b1; o[6] = 1'b1; o[2] = 1'b1; end
        o[1] = st;
        o[0] = busy;
        return o;
    endfunction

    function automatic void model_update();
        bit busy, st;
        busy = MD_EN && (age > 0);
        st   = MD_EN && !busy && IDEX_muldiv_i && !dmem_stall_i && !rst_i;
        if (rst_i) age = 0;
        else if (busy) begin
            if (age >= LAT && !dmem_stall_i) age = 0;
            else age++;
        end else if (st) age = 1;
    endfunction

    task automatic chk_now(input string tag);
        #1;
        if (rst_i) age = 0;
        check(tag, 32'(outs), 32'(model_out()));
    endtask

    task automatic adv();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic clr_inputs();
        IFID_rs1_i = 0; IFID_rs2_i = 0; IDEX_rd_i = 0;
        IDEX_memrd_i = 0; IDEX_muldiv_i = 0; branch_taken_i = 0; dmem_stall_i = 0;
    endtask

    task automatic run_muldiv(input string tag);
        int n   = 0;
        bit seen = 0;
        IDEX_muldiv_i = 1;
        for (int k = 0; k < 4 * LAT && !seen; k++) begin
            chk_now(tag);
            if (k == 0) check({tag, "_start"}, 32'(outs), 32'hE2);
            if (outs[7]) n++;
            else if (outs[0]) seen = 1;
            if (seen) check({tag, "_done"}, 32'(outs), 32'h01);
            adv();
            if (seen) IDEX_muldiv_i = 0;
        end
        check({tag, "_nstall"}, 32'(n), 32'(LAT));
        check({tag, "_seen"}, 32'(seen), 32'd1);
        chk_now({tag, "_idle"});
        check({tag, "_idle0"}, 32'(outs), 32'h00);
    endtask

    initial begin
        rst_i = 1;
        clr_inputs();
        @(negedge clk_i);
        chk_now("reset");
        check("reset_zero", 32'(outs), 32'h00);
        adv();
        rst_i = 0;

        IDEX_memrd_i = 1; IDEX_rd_i = 5; IFID_rs2_i = 5;
        chk_now("loaduse");
        check("loaduse_c", 32'(outs), 32'hC4);
        adv();
        IDEX_memrd_i = 0; IDEX_rd_i = 0;
        chk_now("loaduse_after");
        check("loaduse_after_c", 32'(outs), 32'h00);
        adv();

        IDEX_memrd_i = 1; IDEX_rd_i = 0; IFID_rs2_i = 0;
        chk_now("rd0");
        check("rd0_c", 32'(outs), 32'h00);
        adv();
        IDEX_rd_i = 5; IFID_rs2_i = 5; branch_taken_i = 1;
        chk_now("lu_branch");
        check("lu_branch_c", 32'(outs), 32'h0C);
        adv();
        clr_inputs();

`ifdef MULDIV_EN
        run_muldiv("md");

        IDEX_muldiv_i = 1;
        chk_now("dm_start");
        adv();
        chk_now("dm_busy");
        adv();
        dmem_stall_i = 1;
        for (int k = 0; k < 10; k++) begin
            chk_now("dm_hold");
            check("dm_hold_c", 32'(outs[7:2]), 32'h3C);
            adv();
        end
        dmem_stall_i = 0;
        chk_now("dm_release");
        check("dm_release_c", 32'(outs), 32'h01);
        IDEX_muldiv_i = 0;
        adv();
        chk_now("dm_idle");
        check("dm_idle_c", 32'(outs), 32'h00);
        adv();

        IDEX_muldiv_i = 1;
        chk_now("rst_start");
        adv();
        chk_now("rst_busy");
        adv();
        rst_i = 1;
        IDEX_muldiv_i = 0;
        chk_now("rst_mid");
        check("rst_mid_busy", 32'(muldiv_busy_o), 32'd0);
        adv();
        rst_i = 0;
        chk_now("rst_after");
        check("rst_after_c", 32'(outs), 32'h00);
        adv();
        run_muldiv("md_restart");
`else
        IDEX_muldiv_i = 1;
        for (int k = 0; k < 3; k++) begin
            chk_now("nomd");
            check("nomd_c", 32'(outs), 32'h00);
            adv();
        end
        IDEX_muldiv_i = 0;
`endif

        for (int i = 0; i < 600; i++) begin
            if (rst_i) rst_i = ($urandom_range(0, 3) == 0);
            else       rst_i = ($urandom_range(0, 49) == 0);
            IFID_rs1_i     = 5'($urandom_range(0, 3));
            IFID_rs2_i     = 5'($urandom_range(0, 3));
            IDEX_rd_i      = 5'($urandom_range(0, 3));
            IDEX_memrd_i   = ($urandom_range(0, 9) < 4);
            IDEX_muldiv_i  = ($urandom_range(0, 9) < 2);
            branch_taken_i = ($urandom_range(0, 99) < 15);
            dmem_stall_i   = ($urandom_range(0, 99) < 15);
            chk_now("rand");
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
